// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage -- single valid/ready pipeline register stage.
//
// Holds one payload beat in a main register and presents it downstream with
// exactly one cycle of latency from acceptance. Outputs come straight from
// registers. A synchronous flush kills every held beat without touching the
// payload registers. A saturating counter records back-pressured cycles.
//
// Optional feature (compile-time macro PIPE_STAGE_SKID_EN):
//   defined   : adds a WIDTH-bit skid register and a FULL state, so that
//               in_ready is a registered signal (= !FULL) and upstream never
//               sees a combinational path from out_ready.
//   undefined : no skid storage; in_ready = out_ready || !out_valid.
// ---------------------------------------------------------------------------
module pipe_stage #(
   parameter int               WIDTH    = 32,
   parameter int               CNT_W    = 16,
   parameter logic [WIDTH-1:0] RST_DATA = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] stall_count
);

   // State encoding. FULL is only reachable when the skid register exists.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // -----------------------------------------------------------------------
   // State and datapath registers
   // -----------------------------------------------------------------------
   state_t             state_r;
   state_t             state_s;
   logic               out_valid_r;
   logic               out_valid_s;
   logic [WIDTH-1:0]   main_r;
   logic [WIDTH-1:0]   main_s;
   logic [CNT_W-1:0]   stall_r;
   logic [CNT_W-1:0]   stall_s;
   logic               accept_s;
   logic               stalled_s;

`ifdef PIPE_STAGE_SKID_EN
   logic [WIDTH-1:0]   skid_r;
   logic [WIDTH-1:0]   skid_s;
   logic               in_ready_r;
   logic               in_ready_s;
`endif

   // -----------------------------------------------------------------------
   // Handshake decode
   // -----------------------------------------------------------------------
`ifdef PIPE_STAGE_SKID_EN
   // With a skid slot free, upstream may always send; readiness is a flop.
   assign in_ready  = in_ready_r;
`else
   // Without skid storage the slot frees up in the same cycle it drains.
   assign in_ready  = out_ready | ~out_valid_r;
`endif

   // Flush overrides acceptance: an offered beat in a flush cycle is dropped.
   assign accept_s  = in_valid & in_ready & ~flush;

   // Downstream holds off a beat that is on display.
   assign stalled_s = out_valid_r & ~out_ready;

   assign out_valid   = out_valid_r;
   assign out_data    = main_r;
   assign stall_count = stall_r;

   // State register: async reset returns the stage to EMPTY at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_EMPTY;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: flush wins, otherwise follow the handshake outcome.
   always_comb begin
      state_s = state_r;
      if (flush) begin
         state_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_s = ST_BUSY;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_BUSY: begin
               if (accept_s && out_ready) begin
                  state_s = ST_BUSY;
               end else if (accept_s) begin
`ifdef PIPE_STAGE_SKID_EN
                  // Downstream blocked: park the new beat in the skid slot.
                  state_s = ST_FULL;
`else
                  // Unreachable: in_ready tracks out_ready while BUSY.
                  state_s = ST_BUSY;
`endif
               end else if (out_ready) begin
                  state_s = ST_EMPTY;
               end else begin
                  state_s = ST_BUSY;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
               if (out_ready) begin
                  state_s = ST_BUSY;
               end else begin
                  state_s = ST_FULL;
               end
            end
`endif
            default: begin
               state_s = ST_EMPTY;
            end
         endcase
      end
   end

   // Output/datapath logic: choose what each payload register loads next.
   always_comb begin
      main_s = main_r;
`ifdef PIPE_STAGE_SKID_EN
      skid_s = skid_r;
`endif
      if (flush) begin
         // Payload registers keep their contents; only validity is cleared.
         main_s = main_r;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_s = in_data;
               end else begin
                  main_s = main_r;
               end
            end
            ST_BUSY: begin
               if (accept_s && out_ready) begin
                  main_s = in_data;
               end else if (accept_s) begin
`ifdef PIPE_STAGE_SKID_EN
                  skid_s = in_data;
`else
                  main_s = main_r;
`endif
               end else begin
                  main_s = main_r;
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
               if (out_ready) begin
                  main_s = skid_r;
               end else begin
                  main_s = main_r;
               end
            end
`endif
            default: begin
               main_s = main_r;
            end
         endcase
      end
      // out_valid is a flop copy of "next state is not EMPTY".
      out_valid_s = (state_s != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
      in_ready_s  = (state_s != ST_FULL);
`endif
   end

   // Payload and handshake flops; reset loads the configured payload value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_r      <= RST_DATA;
         out_valid_r <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
         skid_r      <= RST_DATA;
         in_ready_r  <= 1'b1;
`endif
      end else begin
         main_r      <= main_s;
         out_valid_r <= out_valid_s;
`ifdef PIPE_STAGE_SKID_EN
         skid_r      <= skid_s;
         in_ready_r  <= in_ready_s;
`endif
      end
   end

   // Stall counter next value: count blocked cycles, stick at all-ones.
   always_comb begin
      stall_s = stall_r;
      if (stalled_s && (stall_r != STALL_MAX)) begin
         stall_s = stall_r + STALL_ONE;
      end else begin
         stall_s = stall_r;
      end
   end

   // Stall counter register; flush deliberately has no effect here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_r <= '0;
      end else begin
         stall_r <= stall_s;
      end
   end

endmodule

// File: tb/tb_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage -- scoreboard bench for pipe_stage.
// The reference model is a queue of beats the stage should be holding, in
// order; its depth bound is 1 (2 with PIPE_STAGE_SKID_EN). The driver pushes
// accepted beats, the monitor compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_pipe_stage;

   localparam int               WIDTH   = 32;
   localparam int               CNT_W   = 4;
   localparam logic [WIDTH-1:0] RST_VAL = 32'hDEAD_BEEF;
   localparam int               STALL_SAT = 15;
`ifdef PIPE_STAGE_SKID_EN
   localparam int               CAP = 2;
`else
   localparam int               CAP = 1;
`endif

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] stall_count;

   logic [WIDTH-1:0] exp_q[$];
   int               exp_stall;
   int               n_vec;
   int               n_miss;

   pipe_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RST_DATA(RST_VAL)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected in_ready from the model's occupancy.
   function automatic logic model_ready(input int occ, input logic ordy);
      if (CAP == 2) return (occ < 2);
      else          return (ordy || occ == 0);
   endfunction

   // Monitor: compare on the falling edge, then retire transferred beats.
   initial begin
      forever begin
         @(negedge clk);
         check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
         check("in_ready", {63'd0, in_ready}, {63'd0, model_ready(exp_q.size(), out_ready)});
         check("stall_count", {60'd0, stall_count}, exp_stall);
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("out_data_unexpected", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("out_data", {32'd0, out_data}, {32'd0, exp_q[0]});
            end
         end
         if (exp_q.size() != 0) begin
            if (out_ready) void'(exp_q.pop_front());
            else if (exp_stall < STALL_SAT) exp_stall++;
         end
      end
   end

   // One clock of stimulus; called at posedge+2, returns at next posedge+2.
   task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                        input logic ordy, input logic fl);
      logic acc;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      acc = rst && iv && model_ready(exp_q.size(), ordy) && !fl;
      @(posedge clk);
      if (rst) begin
         if (fl) exp_q.delete();
         else if (acc) exp_q.push_back(d);
      end
      #2;
   endtask

   // Asynchronous reset between edges; outputs must clear before any edge.
   task automatic mid_reset();
      #1 rst = 1'b0;
      exp_q.delete();
      exp_stall = 0;
      #1;
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_data", {32'd0, out_data}, {32'd0, RST_VAL});
      check("rst_stall", {60'd0, stall_count}, 64'd0);
      in_valid = 1'b1;
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      n_vec = 0; n_miss = 0; exp_stall = 0;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("reset_out_data", {32'd0, out_data}, {32'd0, RST_VAL});
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      rst = 1'b1;

      // Single beat straight through.
      cycle(1'b1, 32'h0000_0013, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      // Back-to-back stream without bubbles.
      for (int i = 1; i <= 3; i++) cycle(1'b1, i, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      // Back-pressure: 0xAA held, then 0xBB offered behind it.
      cycle(1'b1, 32'h0000_00AA, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'h0000_00BB, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      // Flush with a beat held and another offered.
      cycle(1'b1, 32'h0000_0077, 1'b0, 1'b0);
      cycle(1'b1, 32'h0000_0055, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      // Saturation of the stall counter.
      cycle(1'b1, 32'h0000_0099, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      // Reset in the middle of a stream.
      cycle(1'b1, 32'h0000_0101, 1'b1, 1'b0);
      cycle(1'b1, 32'h0000_0102, 1'b0, 1'b0);
      mid_reset();
      cycle(1'b1, 32'h0000_0103, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

      // Random traffic with occasional flush and reset.
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 249) == 0) begin
            mid_reset();
         end else begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
         end
      end
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
